// File: rtl/lt100_timer_target_if.sv
// lt100 bus target-side signal bundle: request fields from the initiator,
// completion/response fields back from the target.
interface lt100_timer_target_if;
    logic        enable;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] i_data;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] o_data;
    logic        bus_err;

    modport master (
        output enable, wr_en, addr, i_data, be,
        input  ready, o_data, bus_err
    );

    modport slave (
        input  enable, wr_en, addr, i_data, be,
        output ready, o_data, bus_err
    );
endinterface

// File: rtl/lt100_timer_target.sv
// lt100 timer target: prescaled 32-bit up-counter with compare, sticky match
// flag and level interrupt, behind a 16-byte register window.
//
// Register window (offset = addr[3:2]):
//   0 CTRL   [0] run, [1] auto_reload, [2] irq_en, [3] one_shot (optional)
//   1 COUNT  read/write
//   2 CMP    read/write
//   3 STATUS [0] match, sticky, write-1-to-clear
//
// Optional feature macro: LT_TIMER_ONESHOT_EN
//   defined   -> CTRL[3] one_shot is implemented; a match tick clears run.
//   undefined -> CTRL[3] reads 0 and ignores writes.
//
// Bus FSM:
//   state    | meaning
//   S_IDLE   | waiting for enable; request fields latched on acceptance
//   S_WAIT   | inserting WAIT_STATES cycles (down-counter to 1)
//   S_ACCESS | single register side effect / read capture, ready rises
//   S_RESP   | holding response until initiator drops enable
module lt100_timer_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PRESCALE    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lt100_timer_target_if.slave  bus,
    output logic                 irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_wr;
    logic [31:2] lat_addr;
    logic [31:0] lat_data;
    logic [3:0]  lat_be;

    logic        ctrl_run;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
`ifdef LT_TIMER_ONESHOT_EN
    logic        ctrl_one_shot;
`endif
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic [PW-1:0] presc;

    logic        hit;
    logic        acc_wr;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic        tick;
    logic        cmp_hit;
    logic        status_clr;
    logic [31:0] ctrl_word;
    logic [31:0] rd_word;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Writes are qualified by the ACCESS state so each request has exactly one side effect.
    assign hit        = (lat_addr[31:4] == BASE_ADDR[31:4]);
    assign acc_wr     = (state == S_ACCESS) && lat_wr && hit;
    assign wr_ctrl    = acc_wr && (lat_addr[3:2] == 2'd0);
    assign wr_count   = acc_wr && (lat_addr[3:2] == 2'd1);
    assign wr_cmp     = acc_wr && (lat_addr[3:2] == 2'd2);
    assign wr_status  = acc_wr && (lat_addr[3:2] == 2'd3);
    assign status_clr = wr_status && lat_be[0] && lat_data[0];
    assign tick       = ctrl_run && (presc == PRESC_LAST);
    assign cmp_hit    = tick && (count == cmp);

    // Assemble the CTRL view and the read mux.
    always_comb begin
        ctrl_word    = '0;
        ctrl_word[0] = ctrl_run;
        ctrl_word[1] = ctrl_auto_reload;
        ctrl_word[2] = ctrl_irq_en;
`ifdef LT_TIMER_ONESHOT_EN
        ctrl_word[3] = ctrl_one_shot;
`endif
        case (lat_addr[3:2])
            2'd0:    rd_word = ctrl_word;
            2'd1:    rd_word = count;
            2'd2:    rd_word = cmp;
            default: rd_word = {31'd0, match};
        endcase
    end

    // Bus handshake FSM with registered ready/o_data/bus_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            bus.ready   <= 1'b0;
            bus.o_data  <= '0;
            bus.bus_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        lat_wr   <= bus.wr_en;
                        lat_addr <= bus.addr[31:2];
                        lat_data <= bus.i_data;
                        lat_be   <= bus.be;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    bus.ready   <= 1'b1;
                    bus.bus_err <= !hit;
                    bus.o_data  <= (hit && !lat_wr) ? rd_word : 32'd0;
                    state       <= S_RESP;
                end
                default: begin
                    if (!bus.enable) begin
                        bus.ready   <= 1'b0;
                        bus.bus_err <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // CTRL register; a bus write outranks the one-shot auto-clear of run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_run         <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
`ifdef LT_TIMER_ONESHOT_EN
            ctrl_one_shot    <= 1'b0;
`endif
        end else if (wr_ctrl) begin
            if (lat_be[0]) begin
                ctrl_run         <= lat_data[0];
                ctrl_auto_reload <= lat_data[1];
                ctrl_irq_en      <= lat_data[2];
`ifdef LT_TIMER_ONESHOT_EN
                ctrl_one_shot    <= lat_data[3];
`endif
            end
        end else begin
`ifdef LT_TIMER_ONESHOT_EN
            if (cmp_hit && ctrl_one_shot) ctrl_run <= 1'b0;
`endif
        end
    end

    // Prescaler, counter, compare and sticky match; bus writes to COUNT beat the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            count <= '0;
            cmp   <= 32'hFFFF_FFFF;
            match <= 1'b0;
        end else begin
            if (!ctrl_run || presc == PRESC_LAST) presc <= '0;
            else                                  presc <= presc + 1'b1;

            if (wr_count)  count <= merge_be(count, lat_data, lat_be);
            else if (tick) count <= (cmp_hit && ctrl_auto_reload) ? 32'd0 : count + 32'd1;

            if (wr_cmp) cmp <= merge_be(cmp, lat_data, lat_be);

            if (cmp_hit)         match <= 1'b1;
            else if (status_clr) match <= 1'b0;
        end
    end

    // Registered interrupt level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= match & ctrl_irq_en;
    end

endmodule

// File: tb/tb_lt100_timer_target.sv
// Scoreboard bench for lt100_timer_target: stimulus pushes the expected
// response of every bus request; a monitor pops and compares on each ready rise.
module tb_lt100_timer_target;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    lt100_timer_target_if bus();

    lt100_timer_target #(
        .BASE_ADDR(BASE), .WAIT_STATES(WS), .PRESCALE(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: 0 exact data, 1 data must exceed expected, 2 data not checked
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          mode;
        int          rise;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares each completed response against the scoreboard head.
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.ready && !prev_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0, 1'b0);
            end else begin
                e = sb_q.pop_front();
                if (e.mode == 0)
                    chk({e.name, "_data"}, bus.o_data, e.data, bus.o_data === e.data);
                else if (e.mode == 1)
                    chk({e.name, "_data_gt"}, bus.o_data, e.data, bus.o_data > e.data);
                chk({e.name, "_err"}, 32'(bus.bus_err), 32'(e.err), bus.bus_err === e.err);
                chk({e.name, "_latency"}, 32'(cyc - e.rise), 32'(WS + 2), (cyc - e.rise) == WS + 2);
            end
        end
        prev_ready = bus.ready;
    end

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                        input int mode, input int hold, input string nm, output int rdy_cyc);
        exp_t e;
        int n;
        @(negedge clk);
        e.data = exp_d; e.err = exp_e; e.mode = mode; e.rise = cyc; e.name = nm;
        sb_q.push_back(e);
        bus.enable = 1'b1; bus.wr_en = wr; bus.addr = a; bus.i_data = d; bus.be = b;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ready && n < 50);
        if (!bus.ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1, 1'b0);
        rdy_cyc = cyc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_ready"}, 32'(bus.ready), 32'd1, bus.ready === 1'b1);
        end
        bus.enable = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.ready && n < 10);
        if (bus.ready) chk({nm, "_release_timeout"}, 32'd1, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] b, input string nm);
        int rc;
        xfer(1'b1, BASE + off, d, b, 32'd0, 1'b0, 2, 0, nm, rc);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input int mode, input string nm);
        int rc;
        xfer(1'b0, BASE + off, 32'd0, 4'hF, exp, 1'b0, mode, 0, nm, rc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;
        int n;
        bus.enable = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.i_data = '0; bus.be = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        chk("reset_irq", 32'(irq), 32'd0, irq === 1'b0);
        rd(32'h0, 32'h0, 0, "rst_ctrl");
        rd(32'h4, 32'h0, 0, "rst_count");
        rd(32'h8, 32'hFFFF_FFFF, 0, "rst_cmp");
        rd(32'hC, 32'h0, 0, "rst_status");

        // Byte lanes
        wr(32'h4, 32'h0, 4'hF, "wr_count0");
        wr(32'h4, 32'hAABB_CCDD, 4'b0010, "wr_count_lane1");
        rd(32'h4, 32'h0000_CC00, 0, "rd_count_lane1");
        wr(32'h0, 32'h7, 4'b0000, "wr_ctrl_be0");
        rd(32'h0, 32'h0, 0, "rd_ctrl_be0");

        // Decode miss
        xfer(1'b1, BASE + 32'h10, 32'h7, 4'hF, 32'h0, 1'b1, 0, 0, "miss_wr", rc);
        xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, 32'h0, 1'b1, 0, 0, "miss_rd", rc);
        rd(32'h0, 32'h0, 0, "after_miss_ctrl");
        rd(32'h4, 32'h0000_CC00, 0, "after_miss_count");

        // Enable held after ready: single response, single write
        xfer(1'b1, BASE + 32'h4, 32'h1234, 4'hF, 32'h0, 1'b0, 2, 5, "hold_wr", rc);
        rd(32'h4, 32'h1234, 0, "hold_rd_count");
        rd(32'h7, 32'h1234, 0, "rd_count_addr_lsb");

        // Match with auto-reload and interrupt
        wr(32'h4, 32'h0, 4'hF, "m_count0");
        wr(32'h8, 32'h5, 4'hF, "m_cmp5");
        xfer(1'b1, BASE, 32'h7, 4'hF, 32'h0, 1'b0, 2, 0, "m_ctrl7", rc);
        n = 0;
        do begin @(negedge clk); n++; end while (!irq && n < 200);
        chk("irq_rise_delay", 32'(cyc - rc), 32'd97, irq === 1'b1 && (cyc - rc) == 97);
        rd(32'hC, 32'h1, 0, "m_status");
        rd(32'h4, 32'h0, 0, "m_count_reload");
        wr(32'hC, 32'h1, 4'h1, "m_w1c");
        chk("irq_cleared", 32'(irq), 32'd0, irq === 1'b0);
        wr(32'h0, 32'h0, 4'hF, "m_stop");
        rd(32'hC, 32'h0, 0, "m_status_clr");

        // Reset while in WAIT
        @(negedge clk);
        bus.enable = 1'b1; bus.wr_en = 1'b1; bus.addr = BASE + 32'h4; bus.i_data = 32'h55; bus.be = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(bus.ready), 32'd0, bus.ready === 1'b0);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h4, 32'h0, 0, "rst_mid_count");
        rd(32'h8, 32'hFFFF_FFFF, 0, "rst_mid_cmp");

        // One-shot
        wr(32'h8, 32'h2, 4'hF, "os_cmp2");
        wr(32'h0, 32'h9, 4'hF, "os_ctrl9");
        repeat (80) @(negedge clk);
`ifdef LT_TIMER_ONESHOT_EN
        rd(32'h0, 32'h8, 0, "os_ctrl");
        rd(32'h4, 32'h3, 0, "os_count");
        repeat (40) @(negedge clk);
        rd(32'h4, 32'h3, 0, "os_count_frozen");
`else
        rd(32'h0, 32'h1, 0, "os_ctrl");
        rd(32'h4, 32'h3, 1, "os_count");
        repeat (40) @(negedge clk);
        rd(32'h4, 32'h5, 1, "os_count_running");
`endif
        rd(32'hC, 32'h1, 0, "os_status");
        chk("os_irq_masked", 32'(irq), 32'd0, irq === 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0, sb_q.size() == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lt100_timer_target.md
Name: lt100_timer_target

Overview:
- Memory-mapped timer peripheral. It is a bus responder (target) on the lt100 bus, sitting behind the lt100_bus address decoder.
- Implements the target side of the enable/ready handshake: wr_en, addr, i_data, be in; ready, o_data, bus_err, irq out.
- Provides a prescaled 32-bit up-counter, a compare register and a sticky match flag that drives irq.

Parameters:
- BASE_ADDR, 32'h0000_2000, base of the 16-byte register window; bits [3:0] must be 0.
- WAIT_STATES, 1, extra cycles between accepting a request and asserting ready (0..15).
- PRESCALE, 16, clk cycles per counter tick (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  request valid; initiator holds it high until it samples ready=1.
- wr_en  in  1  1=write, 0=read; stable while enable=1.
- addr  in  32  byte address; stable while enable=1.
- i_data  in  32  write data.
- be  in  4  byte lane enables for writes.
- ready  out  1  access complete.
- o_data  out  32  read data, valid while ready=1.
- bus_err  out  1  decode error, valid while ready=1.
- irq  out  1  level interrupt = STATUS.match & CTRL.irq_en.

Behaviour:
- Reset (async, rst_n=0): ready=0, o_data=0, bus_err=0, irq=0, CTRL=0, COUNT=0, CMP=32'hFFFF_FFFF, STATUS=0, prescaler=0, FSM=IDLE. Reset mid-access aborts the access silently.
- Register map, offset = addr[3:2]:
  - 0 CTRL: [0] run, [1] auto_reload, [2] irq_en; other bits read 0.
  - 1 COUNT: read/write.
  - 2 CMP: read/write.
  - 3 STATUS: [0] match, sticky; write-1-to-clear.
- Decode: hit when addr[31:4]==BASE_ADDR[31:4]. A miss completes normally with bus_err=1, o_data=0, and no register change. addr[1:0] is ignored.
- FSM states:
  - IDLE: on enable=1, latch wr_en, addr, i_data, be; load wait counter with WAIT_STATES; go to WAIT.
  - WAIT: decrement the wait counter; at 0 go to ACCESS. With WAIT_STATES=0, IDLE goes directly to ACCESS.
  - ACCESS: perform the register write (byte lanes per be; be=0 writes nothing) or capture the read word into o_data; set bus_err; ready<=1; go to RESP.
  - RESP: hold ready, o_data and bus_err until enable is sampled 0, then ready<=0, bus_err<=0, and go to IDLE. A new request is accepted no earlier than the cycle after ready falls.
- Latency: enable rise to ready=1 is WAIT_STATES+2 clk edges. Exactly one register side effect occurs per request.
- Reads always return the full 32-bit word regardless of be.
- Counter:
  - When run=1, the prescaler counts 0..PRESCALE-1 and produces a 1-cycle tick at PRESCALE-1, then wraps.
  - run=0 clears the prescaler and freezes COUNT.
  - On tick: if COUNT==CMP then match<=1 and COUNT<=(auto_reload ? 0 : COUNT+1); else COUNT<=COUNT+1.
  - COUNT wraps 32'hFFFF_FFFF -> 0 with no flag.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the bus value wins and the tick increment is dropped. The match check still uses the pre-write COUNT.
  - A W1C on STATUS in the same cycle as a match set: set wins, match stays 1.
  - A write to CMP takes effect for the next tick.
- irq is registered: it updates one cycle after match or irq_en changes.

Optional Feature:
- LT_TIMER_ONESHOT_EN.
  - Defined: CTRL[3] = one_shot (read/write). On a match tick with one_shot=1, run<=0 in the same edge. If a bus write to CTRL lands in that same cycle, the bus write wins.
  - Undefined: CTRL[3] reads 0, writes are ignored, and no run auto-clear occurs.

Test Plan:
- Reset with enable=0 -> read CTRL/COUNT/CMP/STATUS returns 0, 0, 32'hFFFF_FFFF, 0; irq=0; each ready pulse appears exactly WAIT_STATES+2 edges after enable rises.
- Write CMP=5, CTRL=32'h7, PRESCALE=16 -> STATUS.match=1 and irq=1 about 96 cycles after run is set (6 ticks: 0..5); COUNT then restarts at 0; write STATUS=1 clears irq next cycle.
- Write COUNT with be=4'b0010, i_data=32'hAABBCCDD over COUNT=0 -> read returns 32'h0000CC00; CTRL write with be=0 -> unchanged.
- Access addr=BASE_ADDR+32'h10, wr_en=1 -> ready with bus_err=1, o_data=0, no register changes; the next in-window access has bus_err=0.
- Hold enable high 5 cycles after ready -> ready stays high, no second side effect (COUNT written once); assert rst_n=0 in WAIT -> ready=0 immediately, no write lands.
- LT_TIMER_ONESHOT_EN defined, CTRL=32'h9, CMP=2 -> after match, CTRL reads 32'h8 and COUNT stops at 3; without the macro, CTRL reads 32'h1 and COUNT keeps counting.
